// File: rtl/alu_seq.sv
// Registered ALU with an NZCV flag register and shift/rotate ops. MUL runs as a
// W-step shift-add sequence behind a start/busy/done handshake.
module alu_seq #(
  parameter  int W   = 32,
  localparam int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         set_flags,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v
);

  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_RSB = 4'b0010;
  localparam logic [3:0] OP_BIC = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_ORR = 4'b0101;
  localparam logic [3:0] OP_EOR = 4'b0110;
  localparam logic [3:0] OP_EON = 4'b0111;
  localparam logic [3:0] OP_LSL = 4'b1000;
  localparam logic [3:0] OP_LSR = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1110;
  localparam logic [3:0] OP_RSV = 4'b1111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [W-1:0]   mcand_r, mplier_r, acc_r, acc_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic           mul_sf_r;
  logic           mul_last_s;
  logic           busy_r, done_r;
  logic [W-1:0]   result_r;
  logic           n_r, z_r, c_r, v_r;

  logic [W-1:0]   add_x_s, add_y_s;
  logic           add_cin_s;
  logic [W:0]     sum_s;
  logic           arith_v_s;
  logic [SHW-1:0] amt_s;
  logic           amt_nz_s;
  logic [W:0]     lsl_ext_s, lsr_ext_s, asr_ext_s;
  logic [W-1:0]   ror_s;
  logic [W-1:0]   res_s;
  logic           upd_nz_s, upd_c_s, upd_v_s, c_s, v_s;

  assign mul_last_s = (state_r == S_MUL) && (cnt_r == CW'(W - 1));
  assign acc_nxt_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  // Shifter: the extra bit in each extended vector captures the last bit shifted out.
  assign amt_s     = b[SHW-1:0];
  assign amt_nz_s  = |amt_s;
  assign lsl_ext_s = {1'b0, a} << amt_s;
  assign lsr_ext_s = {a, 1'b0} >> amt_s;
  assign asr_ext_s = $signed({a, 1'b0}) >>> amt_s;
  assign ror_s     = W'({a, a} >> amt_s);

  // SUB and RSB reuse the adder as x + ~y + 1, so carry out means "no borrow".
  always_comb begin
    add_x_s   = a;
    add_y_s   = b;
    add_cin_s = 1'b0;
    case (op)
      OP_SUB: begin
        add_y_s   = ~b;
        add_cin_s = 1'b1;
      end
      OP_RSB: begin
        add_x_s   = b;
        add_y_s   = ~a;
        add_cin_s = 1'b1;
      end
      default: begin
        add_x_s   = a;
        add_y_s   = b;
        add_cin_s = 1'b0;
      end
    endcase
    sum_s     = {1'b0, add_x_s} + {1'b0, add_y_s} + {{W{1'b0}}, add_cin_s};
    arith_v_s = (add_x_s[W-1] == add_y_s[W-1]) && (sum_s[W-1] != add_x_s[W-1]);
  end

  // Single-cycle result and per-op flag update enables.
  always_comb begin
    res_s    = '0;
    upd_nz_s = 1'b1;
    upd_c_s  = 1'b0;
    upd_v_s  = 1'b0;
    c_s      = 1'b0;
    v_s      = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_RSB: begin
        res_s   = sum_s[W-1:0];
        upd_c_s = 1'b1;
        upd_v_s = 1'b1;
        c_s     = sum_s[W];
        v_s     = arith_v_s;
      end
      OP_BIC: res_s = a & ~b;
      OP_AND: res_s = a & b;
      OP_ORR: res_s = a | b;
      OP_EOR: res_s = a ^ b;
      OP_EON: res_s = ~(a ^ b);
      OP_LSL: begin
        res_s   = lsl_ext_s[W-1:0];
        upd_c_s = amt_nz_s;
        c_s     = lsl_ext_s[W];
      end
      OP_LSR: begin
        res_s   = lsr_ext_s[W:1];
        upd_c_s = amt_nz_s;
        c_s     = lsr_ext_s[0];
      end
      OP_ASR: begin
        res_s   = asr_ext_s[W:1];
        upd_c_s = amt_nz_s;
        c_s     = asr_ext_s[0];
      end
      OP_ROR: begin
        res_s   = ror_s;
        upd_c_s = amt_nz_s;
        c_s     = ror_s[W-1];
      end
      OP_MUL: upd_nz_s = 1'b0;
      OP_MOV: res_s = b;
      OP_MVN: res_s = ~b;
      OP_RSV: upd_nz_s = 1'b0;
      default: begin
        res_s    = '0;
        upd_nz_s = 1'b0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && (op == OP_MUL)) state_nxt_s = S_MUL;
        else                         state_nxt_s = S_IDLE;
      end
      S_MUL: begin
        if (mul_last_s) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_MUL;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Datapath: result/flag registers, handshake and multiplier iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      {n_r, z_r, c_r, v_r} <= 4'b0000;
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      mul_sf_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state_r == S_IDLE) begin
        if (start && (op == OP_MUL)) begin
          mcand_r  <= a;
          mplier_r <= b;
          acc_r    <= '0;
          cnt_r    <= '0;
          mul_sf_r <= set_flags;
          busy_r   <= 1'b1;
        end else if (start) begin
          result_r <= res_s;
          done_r   <= 1'b1;
          if (set_flags && upd_nz_s) begin
            n_r <= res_s[W-1];
            z_r <= (res_s == '0);
          end
          if (set_flags && upd_c_s) c_r <= c_s;
          if (set_flags && upd_v_s) v_r <= v_s;
        end
      end else begin
        acc_r    <= acc_nxt_s;
        mcand_r  <= {mcand_r[W-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[W-1:1]};
        cnt_r    <= cnt_r + CW'(1);
        if (mul_last_s) begin
          result_r <= acc_nxt_s;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          if (mul_sf_r) begin
            n_r <= acc_nxt_s[W-1];
            z_r <= (acc_nxt_s == '0);
          end
        end
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign flag_n = n_r;
  assign flag_z = z_r;
  assign flag_c = c_r;
  assign flag_v = v_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a W=32 instance for ALU/shift/flag behaviour and a
// W=8 instance for the iterative multiplier and mid-operation reset.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [3:0]  op = 4'b0000;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        set_flags = 1'b0;

  logic        busy32, done32, n32, z32, c32, v32;
  logic [31:0] res32;
  logic        busy8, done8, n8, z8, c8, v8;
  logic [7:0]  res8;
  logic [3:0]  nzcv32, nzcv8;

  int checks = 0;
  int errors = 0;

  assign nzcv32 = {n32, z32, c32, v32};
  assign nzcv8  = {n8, z8, c8, v8};

  always #5 clk = ~clk;

  alu_seq #(.W(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .a(a), .b(b),
    .set_flags(set_flags), .busy(busy32), .done(done32), .result(res32),
    .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32)
  );

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .set_flags(set_flags), .busy(busy8), .done(done8), .result(res8),
    .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8)
  );

  task automatic issue32(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb, input logic s);
    @(negedge clk);
    op = o; a = aa; b = bb; set_flags = s; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb, input logic s);
    @(negedge clk);
    op = o; a = {24'h0, aa}; b = {24'h0, bb}; set_flags = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy32, done32, res32, nzcv32} !== {1'b0, 1'b0, 32'h0, 4'b0000}) begin
      errors++;
      $display("FAIL reset32 got busy=%b done=%b res=%h nzcv=%b expected 0 0 00000000 0000", busy32, done32, res32, nzcv32);
    end
    checks++;
    if ({busy8, done8, res8, nzcv8} !== {1'b0, 1'b0, 8'h0, 4'b0000}) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b res=%h nzcv=%b expected 0 0 00 0000", busy8, done8, res8, nzcv8);
    end
    reset = 1'b0;
  endtask

  task automatic test_arith;
    issue32(4'b0000, 32'h7FFF_FFFF, 32'h1, 1'b1);
    checks++;
    if ({done32, res32, nzcv32} !== {1'b1, 32'h8000_0000, 4'b1001}) begin
      errors++;
      $display("FAIL add_ovf got done=%b res=%h nzcv=%b expected 1 80000000 1001", done32, res32, nzcv32);
    end
    issue32(4'b0001, 32'h5, 32'h5, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'h0, 4'b0110}) begin
      errors++;
      $display("FAIL sub_eq got res=%h nzcv=%b expected 00000000 0110", res32, nzcv32);
    end
    issue32(4'b0100, 32'hF0, 32'h0F, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'h0, 4'b0110}) begin
      errors++;
      $display("FAIL and_keep_cv got res=%h nzcv=%b expected 00000000 0110", res32, nzcv32);
    end
    issue32(4'b0000, 32'h1, 32'h1, 1'b0);
    checks++;
    if ({done32, res32, nzcv32} !== {1'b1, 32'h2, 4'b0110}) begin
      errors++;
      $display("FAIL add_nos got done=%b res=%h nzcv=%b expected 1 00000002 0110", done32, res32, nzcv32);
    end
    @(posedge clk); #1;
    checks++;
    if ({done32, res32} !== {1'b0, 32'h2}) begin
      errors++;
      $display("FAIL done_drop got done=%b res=%h expected 0 00000002", done32, res32);
    end
    issue32(4'b0001, 32'h3, 32'hA, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'hFFFF_FFF9, 4'b1000}) begin
      errors++;
      $display("FAIL sub_borrow got res=%h nzcv=%b expected fffffff9 1000", res32, nzcv32);
    end
  endtask

  task automatic test_logic;
    issue32(4'b0011, 32'h0000_00FF, 32'h0000_000F, 1'b0);
    checks++;
    if (res32 !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL bic got %h expected 000000f0", res32);
    end
    issue32(4'b0111, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
    checks++;
    if (res32 !== 32'h0F0F_F0F0) begin
      errors++;
      $display("FAIL eon got %h expected 0f0ff0f0", res32);
    end
    issue32(4'b0101, 32'h1200_0000, 32'h0000_0034, 1'b0);
    checks++;
    if ({res32, nzcv32} !== {32'h1200_0034, 4'b1000}) begin
      errors++;
      $display("FAIL orr got res=%h nzcv=%b expected 12000034 1000", res32, nzcv32);
    end
  endtask

  task automatic test_shifts;
    issue32(4'b1001, 32'h3, 32'h1, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'h1, 4'b0010}) begin
      errors++;
      $display("FAIL lsr got res=%h nzcv=%b expected 00000001 0010", res32, nzcv32);
    end
    issue32(4'b1000, 32'h1234_5678, 32'd32, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'h1234_5678, 4'b0010}) begin
      errors++;
      $display("FAIL lsl_amt0 got res=%h nzcv=%b expected 12345678 0010", res32, nzcv32);
    end
    issue32(4'b1010, 32'h8000_0000, 32'd31, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'hFFFF_FFFF, 4'b1000}) begin
      errors++;
      $display("FAIL asr got res=%h nzcv=%b expected ffffffff 1000", res32, nzcv32);
    end
    issue32(4'b1011, 32'h1, 32'h1, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'h8000_0000, 4'b1010}) begin
      errors++;
      $display("FAIL ror got res=%h nzcv=%b expected 80000000 1010", res32, nzcv32);
    end
    issue32(4'b1000, 32'h8000_0001, 32'h4, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'h0000_0010, 4'b0000}) begin
      errors++;
      $display("FAIL lsl4 got res=%h nzcv=%b expected 00000010 0000", res32, nzcv32);
    end
    issue32(4'b1111, 32'h5, 32'h5, 1'b1);
    checks++;
    if ({done32, res32, nzcv32} !== {1'b1, 32'h0, 4'b0000}) begin
      errors++;
      $display("FAIL reserved got done=%b res=%h nzcv=%b expected 1 00000000 0000", done32, res32, nzcv32);
    end
    issue32(4'b0010, 32'h3, 32'hA, 1'b1);
    checks++;
    if ({res32, nzcv32} !== {32'h7, 4'b0010}) begin
      errors++;
      $display("FAIL rsb got res=%h nzcv=%b expected 00000007 0010", res32, nzcv32);
    end
  endtask

  task automatic test_mul;
    issue8(4'b1100, 8'd13, 8'd11, 1'b1);
    checks++;
    if ({busy8, done8} !== 2'b10) begin
      errors++;
      $display("FAIL mul_accept got busy=%b done=%b expected 1 0", busy8, done8);
    end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) begin
        op = 4'b0000; a = 32'h1; b = 32'h1; set_flags = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      checks++;
      if ({busy8, done8, res8} !== {1'b1, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL mul_busy step %0d got busy=%b done=%b res=%h expected 1 0 00", i, busy8, done8, res8);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8, res8, nzcv8} !== {1'b0, 1'b1, 8'h8F, 4'b1000}) begin
      errors++;
      $display("FAIL mul_done got busy=%b done=%b res=%h nzcv=%b expected 0 1 8f 1000", busy8, done8, res8, nzcv8);
    end
    issue8(4'b0000, 8'd2, 8'd2, 1'b0);
    checks++;
    if ({done8, res8, nzcv8} !== {1'b1, 8'h04, 4'b1000}) begin
      errors++;
      $display("FAIL mul_followon got done=%b res=%h nzcv=%b expected 1 04 1000", done8, res8, nzcv8);
    end
  endtask

  task automatic test_reset_mid_mul;
    issue8(4'b1100, 8'd13, 8'd11, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({busy8, done8, res8, nzcv8} !== {1'b0, 1'b0, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL mul_reset got busy=%b done=%b res=%h nzcv=%b expected 0 0 00 0000", busy8, done8, res8, nzcv8);
    end
    issue8(4'b0000, 8'd2, 8'd3, 1'b0);
    checks++;
    if ({busy8, done8, res8} !== {1'b0, 1'b1, 8'h05}) begin
      errors++;
      $display("FAIL add_after_reset got busy=%b done=%b res=%h expected 0 1 05", busy8, done8, res8);
    end
  endtask

  task automatic test_back_to_back;
    issue32(4'b0110, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
    checks++;
    if ({done32, res32, n32} !== {1'b1, 32'hFFFF_FFFF, 1'b1}) begin
      errors++;
      $display("FAIL b2b_eor got done=%b res=%h n=%b expected 1 ffffffff 1", done32, res32, n32);
    end
    issue32(4'b1110, 32'h0, 32'h0, 1'b1);
    checks++;
    if ({done32, res32, n32} !== {1'b1, 32'hFFFF_FFFF, 1'b1}) begin
      errors++;
      $display("FAIL b2b_mvn got done=%b res=%h n=%b expected 1 ffffffff 1", done32, res32, n32);
    end
    @(posedge clk); #1;
    checks++;
    if (done32 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop got done=%b expected 0", done32);
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic;
    test_shifts;
    test_mul;
    test_reset_mid_mul;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised ALU that succeeds the single-cycle combinational ALU in the datapath.
- Adds shift/rotate ops and an iterative shift-add multiplier.
- Holds an architectural NZCV flag register with ARM-style conditional update (S bit).
- Uses a start/busy/done handshake so the control unit can stall on multi-cycle ops.

Parameters:
- W, 32, operand/result width; must be ≥ 4.
- SHW, $clog2(W), width of shift-amount field taken from b[SHW-1:0]; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  4  operation code, sampled with start
- a  input  W  operand 1, sampled with start
- b  input  W  operand 2 / shift amount, sampled with start
- set_flags  input  1  S bit; 1 = update NZCV on completion, sampled with start
- busy  output  1  multi-cycle op in progress; start ignored
- done  output  1  one-cycle pulse; result (and flags if S) valid this cycle
- result  output  W  registered result, held until next completion
- flag_n, flag_z, flag_c, flag_v  output  1 each  registered NZCV

Behaviour:
- Reset: busy=0, done=0, result=0, NZCV=0000, FSM=IDLE, counter=0. Reset wins over everything, including mid-MUL; the partial product is discarded.
- FSM states:
  - IDLE→IDLE when start=1 and op≠1100.
  - IDLE→MUL when start=1 and op=1100.
  - MUL→IDLE after W steps.
- Single-cycle ops (all except 1100):
  - Operands are sampled at edge k.
  - result, flags and done=1 appear after edge k; done drops after edge k+1 unless a new start is accepted.
  - Back-to-back starts give a done every cycle.
- Op codes:
  - 0000 ADD: a+b.
  - 0001 SUB: a−b.
  - 0010 RSB: b−a.
  - 0011 BIC: a&~b.
  - 0100 AND.
  - 0101 ORR.
  - 0110 EOR.
  - 0111 EON: ~(a^b).
  - 1000 LSL, 1001 LSR, 1010 ASR, 1011 ROR: a shifted by b[SHW-1:0].
  - 1100 MUL: low W bits of a*b.
  - 1101 MOV: b.
  - 1110 MVN: ~b.
  - 1111 reserved: result=0, flags untouched, done still pulses.
- Arithmetic: computed in W+1 bits; C = bit W.
  - SUB/RSB are implemented as x + ~y + 1, so C=1 means no borrow.
  - V=1 iff both addends (after inversion) share a sign bit and the result sign differs.
- Flag update, only when set_flags=1:
  - ADD/SUB/RSB: N, Z, C, V.
  - Logical, MOV, MVN, MUL: N, Z only; C and V keep previous values.
  - Shifts: N, Z; C = last bit shifted out, unchanged if amount=0; V unchanged.
  - ROR: C = result[W-1] when amount≠0.
- set_flags=0: all four flags hold regardless of op.
- Shift boundaries:
  - Amount 0 passes a through unchanged.
  - Amount is modulo 2^SHW, so W=32 uses 5 bits.
  - ASR replicates a[W-1].
- MUL:
  - At the accept edge, latch multiplicand/multiplier, clear the accumulator, set counter=0, busy=1.
  - Each MUL edge: if multiplier LSB=1, add shifted multiplicand to accumulator; shift both; counter++.
  - On the edge completing step W: result=accumulator, flags per rule, done=1, busy=0, FSM=IDLE.
  - Latency is W edges from accept to done; a new start is accepted the cycle done is high.
- start while busy=1: ignored; no effect on operands, result or flags.
- Outputs change only on clk edges; result holds between completions.

Test Plan:
- ADD W=32, a=0x7FFFFFFF, b=1, S=1 -> after 1 edge result=0x80000000, done=1, NZCV=1001.
- SUB a=5, b=5, S=1, then AND a=0xF0, b=0x0F, S=1 -> first completion NZCV=0110; AND gives result=0, NZCV=0110 (C,V preserved); then ADD 1+1 with S=0 -> result=2, flags still 0110.
- LSR a=0x00000003, b=1, S=1 -> result=1, C=1. ASR a=0x80000000, b=31 -> 0xFFFFFFFF, N=1. LSL with b=32 -> amount 0, result=a, C unchanged.
- MUL W=8, a=13, b=11, S=1 -> busy=1 for 8 cycles, done on 8th edge, result=0x8F, N=1, Z=0. A start pulsed mid-MUL is ignored.
- Reset asserted on 4th MUL cycle -> next edge busy=0, done=0, result=0, NZCV=0000; subsequent ADD 2+3 -> result=5 after 1 edge.
- Back-to-back EOR 0xFFFF0000^0x0000FFFF then MVN b=0 -> done high two consecutive cycles, results 0xFFFFFFFF then 0xFFFFFFFF, N=1 each.
